// File: rtl/main_memory_pkg.sv
// Shared parameters and FSM state type for the cache / main-memory subsystem.
package memory_sub_system_param;

    localparam int MEM_ADDR_LENGTH = 10;
    localparam int WORD_SIZE       = 32;
    localparam int CACHE_LINE_SIZE = 128;
    localparam int WORD_SEL_LENGTH = 2;
    localparam int MEM_LATENCY     = 4;
    localparam int WORDS_PER_LINE  = CACHE_LINE_SIZE / WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } main_mem_state_e;

endpackage

// File: rtl/main_memory_array.sv
// Single-port line storage: asynchronous line read, word-masked write,
// optional whole-line write when MAIN_MEM_LINE_WRITE_EN is defined.
module main_mem_array
    import memory_sub_system_param::*;
#(
    parameter int ADDR_LEN     = MEM_ADDR_LENGTH,
    parameter int WORD_S       = WORD_SIZE,
    parameter int CACHE_L_SIZE = CACHE_LINE_SIZE,
    parameter int WSEL_LEN     = WORD_SEL_LENGTH
) (
    input  logic                    clk,
    input  logic [ADDR_LEN-1:0]     addr,
    input  logic                    word_we,
    input  logic [WSEL_LEN-1:0]     wsel,
    input  logic [WORD_S-1:0]       wdata,
`ifdef MAIN_MEM_LINE_WRITE_EN
    input  logic                    line_we,
    input  logic [CACHE_L_SIZE-1:0] lwdata,
`endif
    output logic [CACHE_L_SIZE-1:0] rdata
);

    logic [CACHE_L_SIZE-1:0] mem [2**ADDR_LEN];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
`ifdef MAIN_MEM_LINE_WRITE_EN
        if (line_we)
            mem[addr] <= lwdata;
        else
`endif
        if (word_we)
            mem[addr][int'(wsel)*WORD_S +: WORD_S] <= wdata;
    end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency main memory responder: line reads, word write-through stores.
// Define MAIN_MEM_LINE_WRITE_EN to add whole-line writes (req_wline/req_lwdata).
module main_memory
    import memory_sub_system_param::*;
#(
    parameter int ADDR_LEN     = MEM_ADDR_LENGTH,
    parameter int WORD_S       = WORD_SIZE,
    parameter int CACHE_L_SIZE = CACHE_LINE_SIZE,
    parameter int WSEL_LEN     = WORD_SEL_LENGTH,
    parameter int LATENCY      = MEM_LATENCY
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_LEN-1:0]     req_addr,
    input  logic [WSEL_LEN-1:0]     req_wsel,
    input  logic [WORD_S-1:0]       req_wdata,
`ifdef MAIN_MEM_LINE_WRITE_EN
    input  logic                    req_wline,
    input  logic [CACHE_L_SIZE-1:0] req_lwdata,
`endif
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [CACHE_L_SIZE-1:0] resp_rdata
);

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    main_mem_state_e         state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [ADDR_LEN-1:0]     addr_q, addr_d;
    logic [WSEL_LEN-1:0]     wsel_q, wsel_d;
    logic [WORD_S-1:0]       wdata_q, wdata_d;
    logic [CACHE_L_SIZE-1:0] rdata_q, rdata_d;
    logic                    wline_q, wline_d;
    logic [CACHE_L_SIZE-1:0] lwdata_q, lwdata_d;

    logic                    commit;
    logic                    c_write;
    logic                    c_wline;
    logic [ADDR_LEN-1:0]     c_addr;
    logic [WSEL_LEN-1:0]     c_wsel;
    logic [WORD_S-1:0]       c_wdata;
    logic [CACHE_L_SIZE-1:0] c_lwdata;
    logic [CACHE_L_SIZE-1:0] arr_rdata;
    logic                    req_wline_i;
    logic [CACHE_L_SIZE-1:0] req_lwdata_i;

`ifdef MAIN_MEM_LINE_WRITE_EN
    assign req_wline_i  = req_wline;
    assign req_lwdata_i = req_lwdata;
`else
    assign req_wline_i  = 1'b0;
    assign req_lwdata_i = '0;
`endif

    // With LATENCY==1 the commit happens on the accept edge, so the array is
    // driven straight from the request inputs; otherwise from the captured copy.
    always_comb begin
        commit   = ((state_q == IDLE) && req_valid && (LATENCY == 1)) ||
                   ((state_q == WAIT) && (cnt_q == '0));
        c_write  = write_q;
        c_wline  = wline_q;
        c_addr   = addr_q;
        c_wsel   = wsel_q;
        c_wdata  = wdata_q;
        c_lwdata = lwdata_q;
        if (state_q == IDLE) begin
            c_write  = req_write;
            c_wline  = req_wline_i;
            c_addr   = req_addr;
            c_wsel   = req_wsel;
            c_wdata  = req_wdata;
            c_lwdata = req_lwdata_i;
        end
    end

    main_mem_array #(
        .ADDR_LEN     (ADDR_LEN),
        .WORD_S       (WORD_S),
        .CACHE_L_SIZE (CACHE_L_SIZE),
        .WSEL_LEN     (WSEL_LEN)
    ) u_array (
        .clk     (clk),
        .addr    (c_addr),
        .word_we (commit && c_write && !c_wline),
        .wsel    (c_wsel),
        .wdata   (c_wdata),
`ifdef MAIN_MEM_LINE_WRITE_EN
        .line_we (commit && c_write && c_wline),
        .lwdata  (c_lwdata),
`endif
        .rdata   (arr_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        wline_d  = wline_q;
        addr_d   = addr_q;
        wsel_d   = wsel_q;
        wdata_d  = wdata_q;
        lwdata_d = lwdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    wline_d  = req_wline_i;
                    addr_d   = req_addr;
                    wsel_d   = req_wsel;
                    wdata_d  = req_wdata;
                    lwdata_d = req_lwdata_i;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0)
                    state_d = RESP;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit)
            rdata_d = c_write ? '0 : arr_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            wline_q  <= 1'b0;
            addr_q   <= '0;
            wsel_q   <= '0;
            wdata_q  <= '0;
            lwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            wline_q  <= wline_d;
            addr_q   <= addr_d;
            wsel_q   <= wsel_d;
            wdata_q  <= wdata_d;
            lwdata_q <= lwdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: directed steps plus random traffic
// against an array-of-lines reference model.
module tb_main_memory;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;

    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [9:0]   req_addr = '0;
    logic [1:0]   req_wsel = '0;
    logic [31:0]  req_wdata = '0;
    logic         req_wline = 1'b0;
    logic [127:0] req_lwdata = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [127:0] resp_rdata;

    logic         b_req_valid = 1'b0;
    logic         b_req_ready;
    logic         b_req_write = 1'b0;
    logic [9:0]   b_req_addr = '0;
    logic [1:0]   b_req_wsel = '0;
    logic [31:0]  b_req_wdata = '0;
    logic         b_req_wline = 1'b0;
    logic [127:0] b_req_lwdata = '0;
    logic         b_resp_valid;
    logic         b_resp_ready = 1'b0;
    logic [127:0] b_resp_rdata;

    int n_total = 0;
    int n_pass  = 0;

    logic [127:0] model [1024];
    logic [9:0]   pool [8];

    always #5 clk = ~clk;

    main_memory #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wsel   (req_wsel),
        .req_wdata  (req_wdata),
`ifdef MAIN_MEM_LINE_WRITE_EN
        .req_wline  (req_wline),
        .req_lwdata (req_lwdata),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata)
    );

    main_memory #(.LATENCY(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_write  (b_req_write),
        .req_addr   (b_req_addr),
        .req_wsel   (b_req_wsel),
        .req_wdata  (b_req_wdata),
`ifdef MAIN_MEM_LINE_WRITE_EN
        .req_wline  (b_req_wline),
        .req_lwdata (b_req_lwdata),
`endif
        .resp_valid (b_resp_valid),
        .resp_ready (b_resp_ready),
        .resp_rdata (b_resp_rdata)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One complete transaction on the LATENCY=LAT instance, resp_ready held
    // low for 'hold' cycles once the response appears.
    task automatic do_req(input bit wr, input bit [9:0] a, input bit [1:0] ws,
                          input bit [31:0] wd, input bit wl, input bit [127:0] lwd,
                          input int hold);
        logic [127:0] exp;
        int n;
        check("ready_before_req", req_ready, 1);
        exp = wr ? 128'h0 : model[a];
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wsel = ws;
        req_wdata = wd; req_wline = wl; req_lwdata = lwd;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                req_valid = 1'b0; req_write = 1'($urandom); req_addr = 10'($urandom);
                req_wsel = 2'($urandom); req_wdata = $urandom; req_wline = 1'($urandom);
            end
        end while (!resp_valid && n < 20);
        check("latency", n, LAT);
        check("resp_rdata", resp_rdata, exp);
        check("ready_busy", req_ready, 0);
        if (wr) begin
            if (wl) model[a] = lwd;
            else    model[a][32*ws +: 32] = wd;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, exp);
            check("hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("done_valid", resp_valid, 0);
        check("done_ready", req_ready, 1);
        check("done_rdata", resp_rdata, 0);
    endtask

    task automatic do_req1(input bit wr, input bit [1:0] ws, input bit [31:0] wd,
                           output int n, output logic [127:0] data);
        b_req_valid = 1'b1; b_req_write = wr; b_req_addr = 10'd0;
        b_req_wsel = ws; b_req_wdata = wd;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (n == 1) b_req_valid = 1'b0;
        end while (!b_resp_valid && n < 20);
        data = b_resp_rdata;
        b_resp_ready = 1'b1;
        @(posedge clk); #1;
        b_resp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        logic [127:0] d;
        logic [127:0] exp5;
        pool = '{10'd0, 10'd1, 10'd3, 10'd5, 10'd9, 10'd512, 10'd1022, 10'd1023};

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Bring every pool line to a known all-zero state through the port.
        foreach (pool[i]) begin
            model[pool[i]] = 128'h0;
            for (int w = 0; w < 4; w++) do_req(1, pool[i], 2'(w), 32'h0, 0, '0, 0);
        end

        do_req(1, 10'd5, 2'd2, 32'hDEADBEEF, 0, '0, 0);
        exp5 = {32'h0, 32'hDEADBEEF, 64'h0};
        check("model_addr5", model[5], exp5);
        do_req(0, 10'd5, 2'd0, 32'h0, 0, '0, 0);
        do_req(0, 10'd5, 2'd0, 32'h0, 0, '0, 6);

        // A second request raised during WAIT must be dropped, not queued.
        do_req(1, 10'd9, 2'd0, 32'h99999999, 0, '0, 0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd5;
        @(posedge clk); #1;
        req_addr = 10'd9;
        n = 1;
        while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        req_valid = 1'b0;
        check("ignore_latency", n, LAT);
        check("ignore_rdata", resp_rdata, model[5]);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        seen = 0;
        repeat (8) begin @(posedge clk); #1; if (resp_valid) seen++; end
        check("ignore_no_second", seen, 0);

        // Reset while a write to addr 3 sits in WAIT drops the write.
        do_req(1, 10'd3, 2'd1, 32'h33333333, 0, '0, 0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd3; req_wsel = 2'd1;
        req_wdata = 32'hBADBAD00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst_wait_ready", req_ready, 1);
        check("rst_wait_valid", resp_valid, 0);
        check("rst_wait_rdata", resp_rdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_req(0, 10'd3, 2'd0, 32'h0, 0, '0, 0);

`ifdef MAIN_MEM_LINE_WRITE_EN
        do_req(1, 10'd1023, 2'd0, 32'h0, 1, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
        do_req(0, 10'd1023, 2'd0, 32'h0, 0, '0, 0);
        do_req(0, 10'd0, 2'd0, 32'h0, 0, '0, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            bit wr;
            bit wl;
            wr = 1'($urandom);
            wl = 1'b0;
`ifdef MAIN_MEM_LINE_WRITE_EN
            wl = ($urandom_range(0, 3) == 0);
`endif
            do_req(wr, pool[$urandom_range(0, 7)], 2'($urandom), $urandom, wl,
                   {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));
        end

        // LATENCY=1 instance: response on the accept edge.
        do_req1(1, 2'd1, 32'hA5A5F00D, n, d);
        check("l1_wr_latency", n, 1);
        check("l1_wr_rdata", d, 0);
        do_req1(0, 2'd0, 32'h0, n, d);
        check("l1_rd_latency", n, 1);
        check("l1_rd_word", d[63:32], 32'hA5A5F00D);
        check("l1_idle", b_req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
